// File: rtl/vga_sync_if.sv
// vga_sync_if: bundles the pixel-tick input and all timing outputs of the VGA
// sync generator.
//   i_en        : pixel tick into the generator
//   o_hcnt      : pixel index within the line
//   o_vcnt      : line index within the frame
//   o_hsync     : horizontal sync (registered)
//   o_vsync     : vertical sync (registered)
//   o_video_on  : visible-area flag (registered)
//   o_line_end  : one-clock strobe on the tick that wraps o_hcnt
//   o_frame_end : one-clock strobe on the tick that wraps the whole frame
// master = the timing generator, slave = its consumer (pattern generator).
interface vga_sync_if #(
    parameter int H_WIDTH = 10,
    parameter int V_WIDTH = 10
);
    logic               i_en;
    logic [H_WIDTH-1:0] o_hcnt;
    logic [V_WIDTH-1:0] o_vcnt;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_video_on;
    logic               o_line_end;
    logic               o_frame_end;

    modport master (
        input  i_en,
        output o_hcnt, o_vcnt, o_hsync, o_vsync, o_video_on,
        output o_line_end, o_frame_end
    );

    modport slave (
        output i_en,
        input  o_hcnt, o_vcnt, o_hsync, o_vsync, o_video_on,
        input  o_line_end, o_frame_end
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA horizontal/vertical timing generator driven by a
// pixel-rate enable strobe. Pure timing, no pixel data.
// Ports:
//   clk    : system clock
//   i_sclr : synchronous active-high reset (wins over the pixel tick)
//   bus    : vga_sync_if master -- i_en pixel tick in; counters, syncs,
//            video_on and line/frame end strobes out
// Sync and video_on are registered from the next-state counter values, so
// they always line up with o_hcnt/o_vcnt in the same cycle.
module vga_sync_gen #(
    parameter int H_DISP   = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_DISP   = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_WIDTH  = 10,
    parameter int V_WIDTH  = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        i_sclr,
    vga_sync_if.master  bus
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [H_WIDTH-1:0] H_LAST = H_WIDTH'(H_TOTAL - 1);
    localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(V_TOTAL - 1);
    localparam logic [H_WIDTH-1:0] H_ONE  = H_WIDTH'(1);
    localparam logic [V_WIDTH-1:0] V_ONE  = V_WIDTH'(1);

    // Inclusive window test on an unsigned count.
    function automatic logic in_win(input int cnt, input int lo, input int hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

    // Map "inside sync window" to the configured pin level.
    function automatic logic sync_level(input logic active);
        return active ? SYNC_POL : !SYNC_POL;
    endfunction

    logic [H_WIDTH-1:0] hcnt_p0;
    logic [V_WIDTH-1:0] vcnt_p0;
    logic               hsync_p0;
    logic               vsync_p0;
    logic               video_on_p0;

    logic               h_wrap;
    logic               v_wrap;
    logic [H_WIDTH-1:0] hcnt_nxt;
    logic [V_WIDTH-1:0] vcnt_nxt;

    // Next-state counters: explicit compare against the last index, so
    // non-power-of-two totals wrap correctly.
    always_comb begin
        h_wrap   = (hcnt_p0 == H_LAST);
        v_wrap   = (vcnt_p0 == V_LAST);
        hcnt_nxt = h_wrap ? '0 : hcnt_p0 + H_ONE;
        vcnt_nxt = vcnt_p0;
        if (h_wrap) begin
            vcnt_nxt = v_wrap ? '0 : vcnt_p0 + V_ONE;
        end
    end

    // Stage p0: counters and decoded timing flags, all updated together.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            hcnt_p0     <= '0;
            vcnt_p0     <= '0;
            hsync_p0    <= sync_level(1'b0);
            vsync_p0    <= sync_level(1'b0);
            video_on_p0 <= 1'b1;
        end else if (bus.i_en) begin
            hcnt_p0     <= hcnt_nxt;
            vcnt_p0     <= vcnt_nxt;
            hsync_p0    <= sync_level(in_win(int'(hcnt_nxt), H_DISP + H_FP,
                                             H_DISP + H_FP + H_SYNC - 1));
            vsync_p0    <= sync_level(in_win(int'(vcnt_nxt), V_DISP + V_FP,
                                             V_DISP + V_FP + V_SYNC - 1));
            video_on_p0 <= (int'(hcnt_nxt) < H_DISP) && (int'(vcnt_nxt) < V_DISP);
        end
    end

    assign bus.o_hcnt     = hcnt_p0;
    assign bus.o_vcnt     = vcnt_p0;
    assign bus.o_hsync    = hsync_p0;
    assign bus.o_vsync    = vsync_p0;
    assign bus.o_video_on = video_on_p0;

    // Strobes mark the tick that performs the wrap; reset suppresses them.
    assign bus.o_line_end  = bus.i_en && !i_sclr && h_wrap;
    assign bus.o_frame_end = bus.o_line_end && v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    // Instance A: full horizontal timing, short frame so wraps are reachable.
    localparam int A_HD = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VD = 6,   A_VF = 2,  A_VS = 2,  A_VB = 3;
    // Instance B: tiny timing for sparse-enable runs.
    localparam int B_HD = 4, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VD = 3, B_VF = 1, B_VS = 1, B_VB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sclr_a = 1'b0;
    logic sclr_b = 1'b0;

    vga_sync_if #(.H_WIDTH(10), .V_WIDTH(10)) ifa ();
    vga_sync_if #(.H_WIDTH(3),  .V_WIDTH(3))  ifb ();

    vga_sync_gen #(
        .H_DISP(A_HD), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
        .V_DISP(A_VD), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
        .H_WIDTH(10), .V_WIDTH(10), .SYNC_POL(1'b0)
    ) dut_a (
        .clk    (clk),
        .i_sclr (sclr_a),
        .bus    (ifa)
    );

    vga_sync_gen #(
        .H_DISP(B_HD), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
        .V_DISP(B_VD), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
        .H_WIDTH(3), .V_WIDTH(3), .SYNC_POL(1'b0)
    ) dut_b (
        .clk    (clk),
        .i_sclr (sclr_b),
        .bus    (ifb)
    );

    typedef struct {
        int dut;
        bit le;
        bit fe;
        int h;
        int v;
        bit hs;
        bit vs;
        bit von;
    } exp_t;

    exp_t q[$];
    int   n_a = 0;          // enable ticks since reset, instance A
    int   n_b = 0;          // enable ticks since reset, instance B
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    function automatic int htot(input int dut);
        return (dut == 0) ? (A_HD + A_HF + A_HS + A_HB) : (B_HD + B_HF + B_HS + B_HB);
    endfunction

    function automatic int vtot(input int dut);
        return (dut == 0) ? (A_VD + A_VF + A_VS + A_VB) : (B_VD + B_VF + B_VS + B_VB);
    endfunction

    // Reference: position is simply the tick count folded into line/frame.
    function automatic void model(input int dut, input int n,
                                  output int h, output int v,
                                  output bit hs, output bit vs, output bit von);
        int hd, hf, hsw, vd, vf, vsw;
        if (dut == 0) begin
            hd = A_HD; hf = A_HF; hsw = A_HS; vd = A_VD; vf = A_VF; vsw = A_VS;
        end else begin
            hd = B_HD; hf = B_HF; hsw = B_HS; vd = B_VD; vf = B_VF; vsw = B_VS;
        end
        h   = n % htot(dut);
        v   = (n / htot(dut)) % vtot(dut);
        hs  = !((h >= hd + hf) && (h < hd + hf + hsw));
        vs  = !((v >= vd + vf) && (v < vd + vf + vsw));
        von = (h < hd) && (v < vd);
    endfunction

    task automatic chk(input string nm, input int dut, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, dut, $time, got, want);
        end
    endtask

    // One clock of stimulus to one instance; the other instance idles.
    task automatic drive(input int dut, input bit sr, input bit en);
        exp_t e;
        int   n, h, v;
        bit   hs, vs, von;
        @(posedge clk);
        #2;
        n = (dut == 0) ? n_a : n_b;
        model(dut, n, h, v, hs, vs, von);
        e.dut = dut;
        e.le  = 1'b0;
        e.fe  = 1'b0;
        if (sr) begin
            n = 0;
        end else if (en) begin
            e.le = (h == htot(dut) - 1);
            e.fe = e.le && (v == vtot(dut) - 1);
            n    = (n + 1) % (htot(dut) * vtot(dut));
        end
        if (dut == 0) begin
            n_a = n; sclr_a = sr; ifa.i_en = en; sclr_b = 1'b0; ifb.i_en = 1'b0;
        end else begin
            n_b = n; sclr_b = sr; ifb.i_en = en; sclr_a = 1'b0; ifa.i_en = 1'b0;
        end
        model(dut, n, e.h, e.v, e.hs, e.vs, e.von);
        q.push_back(e);
    endtask

    // Monitor: strobes checked mid-cycle, registered state just after the edge.
    initial begin
        exp_t e;
        int   h, v, hs, vs, von, le, fe;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    le = int'(ifa.o_line_end); fe = int'(ifa.o_frame_end);
                end else begin
                    le = int'(ifb.o_line_end); fe = int'(ifb.o_frame_end);
                end
                chk("line_end", e.dut, le, int'(e.le));
                chk("frame_end", e.dut, fe, int'(e.fe));
                @(posedge clk);
                #1;
                if (e.dut == 0) begin
                    h = int'(ifa.o_hcnt); v = int'(ifa.o_vcnt); hs = int'(ifa.o_hsync);
                    vs = int'(ifa.o_vsync); von = int'(ifa.o_video_on);
                end else begin
                    h = int'(ifb.o_hcnt); v = int'(ifb.o_vcnt); hs = int'(ifb.o_hsync);
                    vs = int'(ifb.o_vsync); von = int'(ifb.o_video_on);
                end
                chk("hcnt", e.dut, h, e.h);
                chk("vcnt", e.dut, v, e.v);
                chk("hsync", e.dut, hs, int'(e.hs));
                chk("vsync", e.dut, vs, int'(e.vs));
                chk("video_on", e.dut, von, int'(e.von));
            end
        end
    end

    initial begin
        int  h, v;
        bit  hs, vs, von;
        bit  found;
        ifa.i_en = 1'b0;
        ifb.i_en = 1'b0;

        // Instance A: reset, run to an arbitrary count, reset again.
        drive(0, 1'b1, 1'b0);
        repeat (37) drive(0, 1'b0, 1'b1);
        drive(0, 1'b1, 1'b0);
        // Advance to hcnt=5 then hold with no ticks.
        repeat (5) drive(0, 1'b0, 1'b1);
        repeat (20) drive(0, 1'b0, 1'b0);
        // Continuous ticks through a full frame wrap and a little beyond.
        repeat (htot(0) * vtot(0) + 60) drive(0, 1'b0, 1'b1);
        // Random tick pattern with occasional resets.
        repeat (600) drive(0, ($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)));
        // Walk to (700, 9), inside both sync windows, then reset with a tick.
        found = 1'b0;
        for (int i = 0; i < htot(0) * vtot(0); i++) begin
            model(0, n_a, h, v, hs, vs, von);
            if (h == 700 && v == 9) begin
                found = 1'b1;
                break;
            end
            drive(0, 1'b0, 1'b1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_700_9: got not_reached expected reached");
        end
        drive(0, 1'b1, 1'b1);
        repeat (10) drive(0, 1'b0, 1'b1);

        // Instance B: sparse ticks, one every fourth clock, three frames.
        drive(1, 1'b1, 1'b0);
        repeat (htot(1) * vtot(1) * 3) begin
            drive(1, 1'b0, 1'b1);
            repeat (3) drive(1, 1'b0, 1'b0);
        end
        // Random ticks and resets, including reset coinciding with a tick.
        repeat (400) drive(1, ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));

        drive(1, 1'b0, 1'b0);
        stim_done = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates VGA horizontal/vertical timing from a pixel-rate enable strobe: pixel/line counters, sync pulses, active-video flag and line/frame end strobes. Sits directly downstream of the enable prescaler chain (enable-gated counters) and upstream of the pixel/pattern generator and the top-level sync pins. Pure timing: no pixel data path.

## Interface
- H_DISP, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_WIDTH, 10, width of o_hcnt; must hold H_TOTAL-1
- V_WIDTH, 10, width of o_vcnt; must hold V_TOTAL-1
- SYNC_POL, 0, active level of o_hsync/o_vsync (0 = active-low)

- clk  in  1  system clock
- i_sclr  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high
- i_en  in  1  pixel tick; counters advance only on cycles with i_en=1
- o_hcnt  out  H_WIDTH  pixel index in line, 0..H_TOTAL-1
- o_vcnt  out  V_WIDTH  line index in frame, 0..V_TOTAL-1
- o_hsync  out  1  horizontal sync, registered
- o_vsync  out  1  vertical sync, registered
- o_video_on  out  1  high when (o_hcnt, o_vcnt) is in visible area, registered
- o_line_end  out  1  one-clk strobe: i_en=1 and o_hcnt=H_TOTAL-1
- o_frame_end  out  1  one-clk strobe: o_line_end=1 and o_vcnt=V_TOTAL-1

## Operation
- H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525).
- Horizontal phase (decoded from o_hcnt): DISP 0..H_DISP-1 -> FP -> SYNC [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] (656..751) -> BP -> wrap to DISP. Vertical identical on o_vcnt (vsync lines 490..491).
- On i_sclr=1 (priority over i_en): o_hcnt=0, o_vcnt=0, o_hsync=o_vsync=~SYNC_POL (inactive), o_video_on=1.
- Else if i_en=1: o_hcnt increments; at H_TOTAL-1 wraps to 0 and o_vcnt increments; o_vcnt at V_TOTAL-1 with line wrap goes to 0.
- Else: all registers hold.
- o_hsync/o_vsync/o_video_on are registered from the next-state counter values, so they are always consistent with o_hcnt/o_vcnt in the same cycle (no one-cycle skew, no glitches).
- o_video_on = (o_hcnt < H_DISP) && (o_vcnt < V_DISP).
- o_hsync = SYNC_POL when o_hcnt in SYNC window, else ~SYNC_POL; o_vsync likewise on o_vcnt, independent of o_hcnt.
- o_line_end/o_frame_end are combinational, qualified by i_en and forced 0 while i_sclr=1.
- Counter arithmetic is unsigned; compares against H_TOTAL-1/V_TOTAL-1 only (no reliance on natural binary overflow).

## Timing
- Latency: counters and registered outputs change on the clk edge where i_en=1; visible one cycle later, all together.
- i_en may be continuous or sparse (any duty); behaviour depends only on count of i_en cycles.
- o_line_end is high exactly in the clk cycle whose edge wraps o_hcnt to 0; downstream uses it as its own enable.
- Reset mid-line/mid-frame: next cycle state equals post-reset state regardless of phase; strobes low that cycle.
- Simultaneous i_sclr and i_en: reset wins, no increment, no strobe.

## Test plan
- Reset: i_sclr=1 one cycle at arbitrary count -> hcnt=0, vcnt=0, hsync=vsync=1, video_on=1; line_end=0.
- Hold: i_en=0 for 20 clks at hcnt=5 -> all outputs unchanged, no strobes.
- Line timing, i_en continuous: hsync falls when hcnt becomes 656, rises at 752; video_on falls at hcnt=640; line_end pulses at hcnt=799, next hcnt=0, vcnt+1.
- Frame wrap: at (799,524) with i_en -> frame_end=1, next (0,0), video_on=1; vsync low exactly for vcnt 490..491.
- Sparse enable (i_en every 4th clk) with small params H=4/1/2/1, V=3/1/1/1 -> H_TOTAL=8, V_TOTAL=6 sequence identical to continuous case per enable; hsync low for hcnt 5..6.
- Reset mid-sync (hcnt=700, vcnt=491) with i_en=1 same cycle -> (0,0), both syncs inactive next cycle, no strobe.
